// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared MDU operation codes, controller state encodings and the long-operation classifier
// used by the EX-side issue controller.
package mdu_issue_ctrl_pkg;

  localparam logic [3:0] MT_NONE   = 4'd0;
  localparam logic [3:0] MT_MULT   = 4'd1;
  localparam logic [3:0] MT_MULTU  = 4'd2;
  localparam logic [3:0] MT_MADD   = 4'd3;
  localparam logic [3:0] MT_MADDU  = 4'd4;
  localparam logic [3:0] MT_MSUB   = 4'd5;
  localparam logic [3:0] MT_MSUBU  = 4'd6;
  localparam logic [3:0] MT_DIV    = 4'd7;
  localparam logic [3:0] MT_DIVU   = 4'd8;
  localparam logic [3:0] MT_SET_HI = 4'd9;
  localparam logic [3:0] MT_SET_LO = 4'd10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
  } mdu_op_t;

  // Operations that keep the unit busy for several cycles; HI/LO sets complete at the start edge.
  function automatic logic is_long_op(input logic [3:0] ctrl);
    logic long_v;
    case (ctrl)
      MT_MULT, MT_MULTU, MT_MADD, MT_MADDU,
      MT_MSUB, MT_MSUBU, MT_DIV, MT_DIVU: long_v = 1'b1;
      default:                            long_v = 1'b0;
    endcase
    return long_v;
  endfunction

endpackage

// File: rtl/mdu_issue_ctrl.sv
// EX-stage front end for the multiply/divide unit: issues operations, buffers one pending
// operation while the unit is busy, and stalls reads that would return stale HI/LO.
module mdu_issue_ctrl
  import mdu_issue_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  req_ctrl,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        rd_valid,
  input  logic        rd_sel,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] rd_data,
  output logic        mdu_start,
  output logic [3:0]  mdu_ctrl,
  output logic [31:0] mdu_a,
  output logic [31:0] mdu_b,
  input  logic        mdu_busy,
  input  logic [31:0] mdu_hi,
  input  logic [31:0] mdu_lo
);

  logic [1:0] state_r;
  logic [1:0] state_nx;
  logic       buf_v_r;
  logic       buf_v_nx;
  mdu_op_t    buf_op_r;
  mdu_op_t    buf_op_nx;
  logic       start_r;
  logic [3:0] ctrl_r;
  logic [31:0] a_r;
  logic [31:0] b_r;

  logic       active_s;
  logic       req_acc_s;
  logic       buf_go_s;
  logic       launch_s;
  mdu_op_t    launch_op_s;
  mdu_op_t    req_op_s;

  // ISSUE is active because the unit only raises busy the cycle after start.
  assign active_s  = (state_r == ST_ISSUE) | ((state_r == ST_RUN) & mdu_busy);
  assign stall     = (req_valid & buf_v_r) | (rd_valid & (active_s | buf_v_r));
  assign req_acc_s = req_valid & ~buf_v_r & ~flush;
  assign buf_go_s  = buf_v_r & ~flush;
  assign req_op_s  = '{ctrl: req_ctrl, a: req_a, b: req_b};
  assign rd_data   = rd_sel ? mdu_hi : mdu_lo;

  assign mdu_start = start_r;
  assign mdu_ctrl  = ctrl_r;
  assign mdu_a     = a_r;
  assign mdu_b     = b_r;

  // Next-state, buffer and launch selection; a launch always moves the FSM to ISSUE.
  always_comb begin
    state_nx    = state_r;
    buf_v_nx    = buf_v_r & ~flush;
    buf_op_nx   = buf_op_r;
    launch_s    = 1'b0;
    launch_op_s = buf_op_r;
    case (state_r)
      ST_IDLE: begin
        if (buf_go_s) begin
          launch_s    = 1'b1;
          launch_op_s = buf_op_r;
          buf_v_nx    = 1'b0;
          state_nx    = ST_ISSUE;
        end else if (req_acc_s) begin
          launch_s    = 1'b1;
          launch_op_s = req_op_s;
          state_nx    = ST_ISSUE;
        end else begin
          state_nx    = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (req_acc_s) begin
          buf_v_nx  = 1'b1;
          buf_op_nx = req_op_s;
        end else begin
          buf_op_nx = buf_op_r;
        end
        if (is_long_op(ctrl_r)) begin
          state_nx    = ST_RUN;
        end else if (buf_go_s) begin
          launch_s    = 1'b1;
          launch_op_s = buf_op_r;
          buf_v_nx    = 1'b0;
          state_nx    = ST_ISSUE;
        end else begin
          state_nx    = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (mdu_busy) begin
          if (req_acc_s) begin
            buf_v_nx  = 1'b1;
            buf_op_nx = req_op_s;
          end else begin
            buf_op_nx = buf_op_r;
          end
        end else if (buf_go_s) begin
          launch_s    = 1'b1;
          launch_op_s = buf_op_r;
          buf_v_nx    = 1'b0;
          state_nx    = ST_ISSUE;
        end else if (req_acc_s) begin
          launch_s    = 1'b1;
          launch_op_s = req_op_s;
          state_nx    = ST_ISSUE;
        end else begin
          state_nx    = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        buf_v_nx = 1'b0;
      end
    endcase
  end

  // State, pending buffer and the registered unit-side outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      buf_v_r  <= 1'b0;
      buf_op_r <= '0;
      start_r  <= 1'b0;
      ctrl_r   <= 4'd0;
      a_r      <= 32'd0;
      b_r      <= 32'd0;
    end else begin
      state_r  <= state_nx;
      buf_v_r  <= buf_v_nx;
      buf_op_r <= buf_op_nx;
      start_r  <= launch_s;
      if (launch_s) begin
        ctrl_r <= launch_op_s.ctrl;
        a_r    <= launch_op_s.a;
        b_r    <= launch_op_s.b;
      end else begin
        ctrl_r <= ctrl_r;
        a_r    <= a_r;
        b_r    <= b_r;
      end
    end
  end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Bench for mdu_issue_ctrl: behavioural MDU, directed timing scenarios, then random traffic
// checked against an architectural HI/LO reference.
module tb_mdu_issue_ctrl;
  import mdu_issue_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [3:0]  req_ctrl = 4'd0;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic        rd_valid = 1'b0;
  logic        rd_sel = 1'b0;
  logic        flush = 1'b0;
  logic        stall;
  logic [31:0] rd_data;
  logic        mdu_start;
  logic [3:0]  mdu_ctrl;
  logic [31:0] mdu_a;
  logic [31:0] mdu_b;
  logic        mdu_busy;
  logic [31:0] mdu_hi;
  logic [31:0] mdu_lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu_issue_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ctrl(req_ctrl),
    .req_a(req_a), .req_b(req_b), .rd_valid(rd_valid), .rd_sel(rd_sel),
    .flush(flush), .stall(stall), .rd_data(rd_data), .mdu_start(mdu_start),
    .mdu_ctrl(mdu_ctrl), .mdu_a(mdu_a), .mdu_b(mdu_b), .mdu_busy(mdu_busy),
    .mdu_hi(mdu_hi), .mdu_lo(mdu_lo)
  );

  function automatic logic [63:0] apply_op(input logic [63:0] hl, input logic [3:0] c,
                                           input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0] up;
    logic [63:0] r;
    sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    up = {32'd0, a} * {32'd0, b};
    case (c)
      MT_MULT:   r = sp;
      MT_MULTU:  r = up;
      MT_MADD:   r = hl + sp;
      MT_MADDU:  r = hl + up;
      MT_MSUB:   r = hl - sp;
      MT_MSUBU:  r = hl - up;
      MT_DIV:    r = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      MT_DIVU:   r = {a % b, a / b};
      MT_SET_HI: r = {a, hl[31:0]};
      MT_SET_LO: r = {hl[63:32], a};
      default:   r = hl;
    endcase
    return r;
  endfunction

  function automatic int latency_of(input logic [3:0] c);
    if (c == MT_DIV || c == MT_DIVU) return 10;
    if (c >= MT_MULT && c <= MT_MSUBU) return 5;
    return 0;
  endfunction

  // Behavioural multiply/divide unit: busy starts the cycle after start, results land when it drops.
  logic [63:0] hilo_m;
  logic [63:0] pend_m;
  int          busy_cnt;
  always @(posedge clk) begin
    if (!reset) begin
      hilo_m   <= 64'd0;
      pend_m   <= 64'd0;
      busy_cnt <= 0;
    end else if (mdu_start) begin
      if (latency_of(mdu_ctrl) == 0) begin
        hilo_m   <= apply_op(hilo_m, mdu_ctrl, mdu_a, mdu_b);
        busy_cnt <= 0;
      end else begin
        pend_m   <= apply_op(hilo_m, mdu_ctrl, mdu_a, mdu_b);
        busy_cnt <= latency_of(mdu_ctrl);
      end
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) hilo_m <= pend_m;
    end
  end
  assign mdu_busy = (busy_cnt != 0);
  assign mdu_hi   = hilo_m[63:32];
  assign mdu_lo   = hilo_m[31:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (mdu_start) chk("start_while_busy", {31'd0, mdu_busy}, 32'd0);
  endtask

  task automatic present_req(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                             output int waited);
    req_valid = 1'b1; req_ctrl = c; req_a = a; req_b = b;
    waited = 0;
    #1;
    while (stall && waited < 40) begin
      step(); waited++; #1;
    end
    chk("req_accept_timeout", {31'd0, stall}, 32'd0);
    step();
    req_valid = 1'b0;
  endtask

  task automatic read_req(input logic sel, output logic [31:0] data, output int waited);
    rd_valid = 1'b1; rd_sel = sel;
    waited = 0;
    #1;
    while (stall && waited < 40) begin
      step(); waited++; #1;
    end
    chk("read_grant_timeout", {31'd0, stall}, 32'd0);
    data = rd_data;
    step();
    rd_valid = 1'b0;
  endtask

  logic [3:0]  op_tab [10] = '{MT_MULT, MT_MULTU, MT_MADD, MT_MADDU, MT_MSUB,
                               MT_MSUBU, MT_DIV, MT_DIVU, MT_SET_HI, MT_SET_LO};
  logic [63:0] ref_hilo;
  logic [31:0] d;
  int          w;
  int          starts;

  initial begin
    // Reset held for two edges.
    step(); step();
    chk("rst_start", {31'd0, mdu_start}, 32'd0);
    chk("rst_ctrl", {28'd0, mdu_ctrl}, 32'd0);
    chk("rst_a", mdu_a, 32'd0);
    chk("rst_b", mdu_b, 32'd0);
    rd_valid = 1'b1; #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    rd_valid = 1'b0;
    reset = 1'b1;
    step();

    // Signed multiply, HI read stalls cycles 1..6.
    present_req(MT_MULT, 32'hFFFF_FFFE, 32'd3, w);
    chk("mult_accept_wait", w, 32'd0);
    chk("mult_start", {31'd0, mdu_start}, 32'd1);
    chk("mult_ctrl", {28'd0, mdu_ctrl}, {28'd0, MT_MULT});
    chk("mult_a", mdu_a, 32'hFFFF_FFFE);
    chk("mult_b", mdu_b, 32'd3);
    read_req(1'b1, d, w);
    chk("mult_hi_wait", w, 32'd6);
    chk("mult_hi", d, 32'hFFFF_FFFF);
    read_req(1'b0, d, w);
    chk("mult_lo_wait", w, 32'd0);
    chk("mult_lo", d, 32'hFFFF_FFFA);

    // Unsigned divide, LO read granted in cycle 12.
    present_req(MT_DIVU, 32'd100, 32'd7, w);
    read_req(1'b0, d, w);
    chk("divu_lo_wait", w, 32'd11);
    chk("divu_lo", d, 32'd14);
    read_req(1'b1, d, w);
    chk("divu_hi", d, 32'd2);

    // LO set: one stall cycle while in ISSUE.
    present_req(MT_SET_LO, 32'h1234_5678, 32'd0, w);
    read_req(1'b0, d, w);
    chk("setlo_wait", w, 32'd1);
    chk("setlo_lo", d, 32'h1234_5678);

    // Back-to-back: second buffered, third stalls until the buffered MADD issues.
    present_req(MT_MULT, 32'd2, 32'd3, w);
    present_req(MT_MADD, 32'd4, 32'd5, w);
    chk("b2b_second_wait", w, 32'd0);
    present_req(MT_SET_HI, 32'h55, 32'd0, w);
    chk("b2b_third_wait", w, 32'd6);
    read_req(1'b0, d, w);
    chk("b2b_lo_wait", w, 32'd7);
    chk("b2b_lo", d, 32'd26);
    read_req(1'b1, d, w);
    chk("b2b_hi", d, 32'h55);

    // Flush of a buffered divide during RUN of a multiply.
    present_req(MT_MULT, 32'd5, 32'd7, w);
    present_req(MT_DIV, 32'd100, 32'd3, w);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    starts = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (mdu_start) starts++;
    end
    chk("flush_no_start", starts, 32'd0);
    read_req(1'b0, d, w);
    chk("flush_lo", d, 32'd35);
    read_req(1'b1, d, w);
    chk("flush_hi", d, 32'd0);

    // Reset in the middle of a divide.
    present_req(MT_DIV, 32'd100, 32'd3, w);
    step(); step(); step();
    reset = 1'b0;
    rd_valid = 1'b1;
    step();
    chk("midrst_start", {31'd0, mdu_start}, 32'd0);
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    rd_valid = 1'b0;
    reset = 1'b1;
    step();
    read_req(1'b0, d, w);
    chk("midrst_read_wait", w, 32'd0);
    ref_hilo = 64'd0;

    // Random traffic against the architectural HI/LO reference.
    for (int i = 0; i < 40; i++) begin
      logic [3:0]  c;
      logic [31:0] a;
      logic [31:0] b;
      c = op_tab[$urandom_range(0, 9)];
      a = $urandom;
      b = (c == MT_DIV || c == MT_DIVU) ? 32'($urandom_range(1, 5000)) : 32'($urandom);
      present_req(c, a, b, w);
      ref_hilo = apply_op(ref_hilo, c, a, b);
      repeat ($urandom_range(0, 2)) step();
      if ($urandom_range(0, 2) == 0) begin
        read_req(1'b0, d, w);
        chk("rand_lo", d, ref_hilo[31:0]);
        read_req(1'b1, d, w);
        chk("rand_hi", d, ref_hilo[63:32]);
      end
    end
    read_req(1'b0, d, w);
    chk("final_lo", d, ref_hilo[31:0]);
    read_req(1'b1, d, w);
    chk("final_hi", d, ref_hilo[63:32]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_issue_ctrl.md
# mdu_issue_ctrl

Pipeline-side front end for the multiply/divide unit: accepts MDU operations and HI/LO reads from the execute stage and drives the unit's start/ctrl/A/B inputs. It watches the unit's busy flag, holds one pending operation in a skid register, and raises a stall so that no read returns stale HI/LO and no start reaches the unit while it is busy. It sits between the EX stage and the multiplier/divider, which keeps its own active-high reset (the top level inverts `reset`).

## Interface
Parameters: none (operation codes come from the shared constants).
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- req_valid  in  1  EX stage presents an MDU operation
- req_ctrl  in  4  operation code (`mt*` constant)
- req_a  in  32  operand A (rs)
- req_b  in  32  operand B (rt)
- rd_valid  in  1  EX stage requests a HI/LO read (mfhi/mflo)
- rd_sel  in  1  1 = HI, 0 = LO
- flush  in  1  discard the buffered, not-yet-issued operation
- stall  out  1  combinational; the presented request is not accepted this cycle
- rd_data  out  32  combinational: rd_sel ? mdu_hi : mdu_lo
- mdu_start  out  1  registered one-cycle start pulse
- mdu_ctrl  out  4  registered operation code
- mdu_a  out  32  registered operand A
- mdu_b  out  32  registered operand B
- mdu_busy  in  1  unit busy flag
- mdu_hi, mdu_lo  in  32  unit result registers

## Operation
- States: IDLE, ISSUE, RUN. One pending buffer: buf_v, buf_ctrl, buf_a, buf_b.
- active = (state==ISSUE) | (state==RUN & mdu_busy). ISSUE counts as active because the unit raises busy one cycle after start.
- IDLE: an accepted request loads mdu_ctrl/a/b, asserts mdu_start next cycle, and the state moves to ISSUE.
- ISSUE: mdu_start=1 for exactly this cycle. Next state is RUN for multiply, multiply-unsigned, MADD, MADDU, MSUB, divide and divide-unsigned. For mtSetHI/mtSetLO, next state is IDLE, or ISSUE again if buf_v is set.
- RUN: stay while mdu_busy=1. Once mdu_busy=0, go to ISSUE with the buffered operation if buf_v is set (buf_v clears), otherwise go to IDLE.
- A request accepted while active, or while in RUN with mdu_busy=0 and buf_v=0, has these outcomes:
  - Active with buf_v=0: it goes to the buffer.
  - Not active (RUN, mdu_busy=0, buf_v=0): it issues directly to ISSUE.
- stall = (req_valid & buf_v) | (rd_valid & (active | buf_v)).
- A read is granted when rd_valid & !stall. rd_data is valid in that cycle only.
- req_valid and rd_valid both high is a protocol violation. The controller stalls the read and processes the request.
- flush clears buf_v on the same edge. An operation already issued (ISSUE/RUN) is never cancelled. If flush and req_valid are both high, the request is dropped.
- mdu_start is never asserted while mdu_busy=1. This is a bench assertion, because the unit's start has priority over busy and would clobber the operation in flight.

## Timing
- Reset (reset=0 at edge): state=IDLE, buf_v=0, mdu_start=0, mdu_ctrl=0, mdu_a=0, mdu_b=0. stall=0 unless buf/active conditions hold, which is impossible immediately after reset.
- Reset mid-operation: the controller returns to IDLE and drops the buffered operation. The unit is reset by the same top-level reset.
- Multiply accepted in cycle 0:
  - mdu_start in cycle 1.
  - mdu_busy high in cycles 2–6.
  - Read stalls in cycles 1–6 and is granted in cycle 7 with the new HI/LO.
- Divide accepted in cycle 0: busy in cycles 2–11, read granted in cycle 12.
- mtSetHI/mtSetLO accepted in cycle 0: start in cycle 1, read granted in cycle 2.
- Back-to-back operations: the second is buffered without stall. It issues (start) in the cycle after RUN sees busy=0. A third request stalls until the buffer drains.

## Structure
- `mt*` operation codes live in the shared constants.v. The state encodings (IDLE/ISSUE/RUN) are added there too.
- A helper classifying long operations (multiply/divide families vs. set) belongs in constants.v as a macro.
- There is no sub-module. The buffer is a single register set inside the block.

## Test plan
- Reset held low 2 cycles, then MULT A=0xFFFFFFFE, B=3 in cycle 0; mfhi requested from cycle 1 → stall in cycles 1–6; in cycle 7, rd_data=0xFFFFFFFF (HI) and a following mflo gives 0xFFFFFFFA.
- DIVU 100/7 in cycle 0 then mflo → granted in cycle 12, rd_data=14; mfhi → 2.
- mtSetLO A=0x12345678 then mflo immediately → one stall cycle (ISSUE), granted in cycle 2 with 0x12345678.
- MULT 2×3, then MADD 4×5 the next cycle (no stall, buffered), then a third op → stall until the MADD issues; mflo after completion = 26; assert mdu_start never coincides with mdu_busy.
- MULT, then buffered DIV, then flush during RUN → DIV never started; LO = product.
- reset=0 during RUN of a DIV → next cycle state IDLE, mdu_start=0, stall=0 with rd_valid high.
